// File: rtl/video_fetch_sched_pkg.sv
// video_defs: shared definitions for the video fetch scheduler.
//   WPL_*          words fetched per line for each screen mode
//   state_t        scheduler state encoding (IDLE / FETCH / DRAIN)
//   words_per_line decodes the one-hot mode inputs into a word count
package video_defs;

  localparam int WPL_ZX   = 32;
  localparam int WPL_PHM  = 32;
  localparam int WPL_P16C = 64;
  localparam int WPL_AG   = 80;
  localparam int WPL_ATXT = 80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Zero means "no mode selected": the line is not started.
  function automatic logic [6:0] words_per_line(input logic zx, input logic phm,
                                                input logic p16c, input logic ag,
                                                input logic atxt);
    if (zx)   return 7'(WPL_ZX);
    if (phm)  return 7'(WPL_PHM);
    if (p16c) return 7'(WPL_P16C);
    if (ag)   return 7'(WPL_AG);
    if (atxt) return 7'(WPL_ATXT);
    return 7'd0;
  endfunction

endpackage

// File: rtl/video_fetch_sched_fifo.sv
// video_fifo: DEPTH x DW word buffer between DRAM return and the serializer.
//   clk, rst        clock, asynchronous active-high reset
//   flush           empties the buffer (pointers and count to zero)
//   push, wdata     write at tail; ignored while full or flushing
//   pop             advance head; ignored while empty or flushing
//   rdata           registered head word, valid while !empty
//   empty, used     occupancy
module video_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     used
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0] used_n;
  logic          push_ok, pop_ok;

  assign push_ok  = push && !flush && (used != CW'(DEPTH));
  assign pop_ok   = pop && !flush && (used != '0);
  assign rd_ptr_n = rd_ptr + AW'(pop_ok);
  assign empty    = (used == '0);

  always_comb begin
    used_n = used;
    if (flush)                 used_n = '0;
    else if (push_ok && !pop_ok) used_n = used + CW'(1);
    else if (!push_ok && pop_ok) used_n = used - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      rdata  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      used   <= used_n;
      // Head register tracks the word at the next head pointer. A word being
      // written into the head slot this cycle is taken from wdata so it shows
      // one cycle after the strobe. While empty the head holds its last value.
      if (used_n != '0)
        rdata <= (push_ok && (wr_ptr == rd_ptr_n)) ? wdata : mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/video_fetch_sched.sv
// video_fetch_sched: per-line video DRAM fetch scheduler with return buffer.
//   line_start/vpix  start a line (vpix sampled with line_start)
//   int_start        frame start: clears flags, flushes, returns to IDLE
//   mode_*           one-hot screen mode, selects words per line
//   video_req        request to arbiter (registered decode, credit limited)
//   video_next       arbiter accepted the request this cycle
//   video_strobe     dram_rddata valid, returns in request order
//   fifo_rd          serializer pop; fifo_rdata/fifo_empty head view
//   busy, underrun, overrun  status; dbg_state exposes the FSM state
//
// Handshake: a request transfers only in a cycle where video_req and
// video_next are both high; video_next while video_req is low is ignored.
// Each transfer produces exactly one later video_strobe. fifo_rd pops only
// when fifo_empty is low; a pop on empty only raises underrun.
module video_fetch_sched
  import video_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line_start,
  input  logic          vpix,
  input  logic          int_start,
  input  logic          mode_zx,
  input  logic          mode_p_hmclr,
  input  logic          mode_p_16c,
  input  logic          mode_ag,
  input  logic          mode_a_text,
  output logic          video_req,
  input  logic          video_next,
  input  logic          video_strobe,
  input  logic [DW-1:0] dram_rddata,
  input  logic          fifo_rd,
  output logic [DW-1:0] fifo_rdata,
  output logic          fifo_empty,
  output logic          busy,
  output logic          underrun,
  output logic          overrun,
  output logic [1:0]    dbg_state
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int SW  = CW + 1;
  // Discard can briefly exceed DEPTH after back-to-back restarts, so it
  // gets one extra bit of headroom.
  localparam int DCW = CW + 1;

  state_t         state, state_n;
  logic [6:0]     remain, words;
  logic [CW-1:0]  outst, outst_adj, used;
  logic [DCW-1:0] discard;
  logic           line_go, start_ok, restart, flush;
  logic           next_ok, strobe_drop, strobe_take;

  assign words       = words_per_line(mode_zx, mode_p_hmclr, mode_p_16c, mode_ag, mode_a_text);
  assign line_go     = line_start & vpix;
  assign start_ok    = line_go & (words != 7'd0);
  assign restart     = line_go & (state != IDLE);
  assign flush       = int_start | restart;
  assign next_ok     = video_next & video_req;
  assign strobe_drop = video_strobe & (discard != '0);
  assign strobe_take = video_strobe & (discard == '0) & (outst != '0);
  // A same-cycle strobe is accounted against outst before any transfer.
  assign outst_adj   = outst - CW'(strobe_take);

  video_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (strobe_take),
    .wdata (dram_rddata),
    .pop   (fifo_rd),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .used  (used)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; frame start and line restart override normal flow.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = FETCH;
      FETCH:   if (remain == 7'd0) state_n = DRAIN;
      DRAIN:   if (outst == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (int_start)    state_n = start_ok ? FETCH : IDLE;
    else if (restart) state_n = FETCH;
  end

  // Outputs, decoded from registers only
  always_comb begin
    busy      = (state != IDLE);
    video_req = (state == FETCH) && (remain != 7'd0) &&
                ((SW'(used) + SW'(outst)) < SW'(DEPTH));
    dbg_state = state;
  end

  // Counters and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain   <= '0;
      outst    <= '0;
      discard  <= '0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (flush) begin
        // Everything still in flight (plus a grant this cycle) belongs to
        // the abandoned line and must be dropped on return.
        outst   <= '0;
        discard <= discard - DCW'(strobe_drop) + DCW'(outst_adj) + DCW'(next_ok);
        remain  <= line_go ? words : 7'd0;
      end else begin
        outst   <= outst_adj + CW'(next_ok);
        discard <= discard - DCW'(strobe_drop);
        if (start_ok && (state == IDLE)) remain <= words;
        else if (next_ok)                remain <= remain - 7'd1;
      end
      if (int_start) begin
        underrun <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        if (fifo_rd && fifo_empty) underrun <= 1'b1;
        if (restart)               overrun  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_fetch_sched.sv
module tb_video_fetch_sched;

  localparam int DEPTH = 4;
  localparam int DW    = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk, rst;
  logic          line_start, vpix, int_start;
  logic          mode_zx, mode_p_hmclr, mode_p_16c, mode_ag, mode_a_text;
  logic          video_req, video_next, video_strobe;
  logic [DW-1:0] dram_rddata, fifo_rdata;
  logic          fifo_rd, fifo_empty, busy, underrun, overrun;
  logic [1:0]    dbg_state;

  video_fetch_sched #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .vpix(vpix), .int_start(int_start),
    .mode_zx(mode_zx), .mode_p_hmclr(mode_p_hmclr), .mode_p_16c(mode_p_16c),
    .mode_ag(mode_ag), .mode_a_text(mode_a_text), .video_req(video_req),
    .video_next(video_next), .video_strobe(video_strobe), .dram_rddata(dram_rddata),
    .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .busy(busy),
    .underrun(underrun), .overrun(overrun), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #18 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [DW-1:0] exp_q[$];          // words the serializer must see, in order
  int            pend_due[$];       // arbiter: cycle each accepted request may return
  int            pend_tag[$];       // arbiter: line generation of each request
  int            gen = 0;           // bumps whenever in-flight words become stale
  int            grants_cur, inflight_cur, delivered_cur, words_cur, idle_cnt;
  bit            active, under_m, over_m;
  logic [DW-1:0] last_head;
  int            pp_cnt[DEPTH+1];   // push+pop same cycle, by occupancy
  int            last_grant = -100;

  // stimulus knobs and one-shot requests
  int grant_gap, grant_pct, lat_min, lat_max, pop_pct, bogus_pct, strobe_pct, mode_sel;
  bit ls_req, vpix_req, is_req, pop_force;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int words_of(input int m);
    case (m)
      0, 1:    return 32;
      2:       return 64;
      3, 4:    return 80;
      default: return 0;
    endcase
  endfunction

  task automatic set_mode(input int m);
    mode_sel     = m;
    mode_zx      = (m == 0);
    mode_p_hmclr = (m == 1);
    mode_p_16c   = (m == 2);
    mode_ag      = (m == 3);
    mode_a_text  = (m == 4);
  endtask

  task automatic compare_all();
    check("fifo_empty", 32'(fifo_empty), 32'(exp_q.size() == 0));
    if (exp_q.size() > 0) check("fifo_rdata", 32'(fifo_rdata), 32'(exp_q[0]));
    check("underrun", 32'(underrun), 32'(under_m));
    check("overrun", 32'(overrun), 32'(over_m));
    check("credit", 32'((exp_q.size() + inflight_cur) <= DEPTH), 32'(1));
    if (!active) idle_cnt++; else idle_cnt = 0;
    if (idle_cnt >= 3) begin
      check("idle_busy", 32'(busy), 32'(0));
      check("idle_req", 32'(video_req), 32'(0));
    end
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_req"},   32'(video_req),  32'(0));
    check({p, "_empty"}, 32'(fifo_empty), 32'(1));
    check({p, "_rdata"}, 32'(fifo_rdata), 32'(0));
    check({p, "_busy"},  32'(busy),       32'(0));
    check({p, "_under"}, 32'(underrun),   32'(0));
    check({p, "_over"},  32'(overrun),    32'(0));
  endtask

  // ---------------- driver: one clock of stimulus + model update ----------------
  task automatic step();
    logic do_next, bogus, do_strobe, do_pop, line_go, start_m, restart_m, flush_m;
    logic pushed, popped;
    int tag, pre_size;
    logic [DW-1:0] d;
    do_next   = video_req && (int'($urandom_range(99)) < grant_pct) && (cyc - last_grant >= grant_gap);
    bogus     = !video_req && (int'($urandom_range(99)) < bogus_pct);
    do_strobe = (pend_due.size() > 0) && (pend_due[0] <= cyc) && (int'($urandom_range(99)) < strobe_pct);
    do_pop    = pop_force || (!fifo_empty && (int'($urandom_range(99)) < pop_pct));
    d         = DW'($urandom);
    line_start   = ls_req;
    vpix         = ls_req && vpix_req;
    int_start    = is_req;
    video_next   = do_next || bogus;
    video_strobe = do_strobe;
    dram_rddata  = d;
    fifo_rd      = do_pop;

    line_go   = ls_req && vpix_req;
    start_m   = line_go && (words_of(mode_sel) != 0);
    restart_m = line_go && active;
    flush_m   = is_req || restart_m;
    pre_size  = exp_q.size();
    if (is_req) begin
      under_m = 1'b0;
      over_m  = 1'b0;
    end else begin
      if (do_pop && pre_size == 0) under_m = 1'b1;
      if (restart_m) over_m = 1'b1;
    end
    popped = do_pop && (pre_size > 0) && !flush_m;
    pushed = 1'b0;
    if (do_strobe) begin
      tag = pend_tag.pop_front();
      void'(pend_due.pop_front());
      if (tag == gen) begin
        inflight_cur--;
        if (!flush_m) begin
          pushed = 1'b1;
          delivered_cur++;
        end
      end
    end
    if (pushed && popped) pp_cnt[pre_size]++;
    if (popped) last_head = exp_q.pop_front();
    if (pushed) exp_q.push_back(d);
    if (do_next) begin
      pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      pend_tag.push_back(gen);
      grants_cur++;
      inflight_cur++;
      last_grant = cyc;
    end
    if (flush_m) begin
      gen++;
      exp_q.delete();
      grants_cur = 0; inflight_cur = 0; delivered_cur = 0;
      words_cur  = words_of(mode_sel);
      active     = is_req ? start_m : 1'b1;
    end else if (start_m) begin
      grants_cur = 0; inflight_cur = 0; delivered_cur = 0;
      words_cur  = words_of(mode_sel);
      active     = 1'b1;
    end
    if (active && grants_cur == words_cur && inflight_cur == 0) active = 1'b0;
    cyc++;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_line(input int max_cycles);
    int n = 0;
    while ((active || exp_q.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    check("line_done", 32'(!active && exp_q.size() == 0), 32'(1));
    repeat (3) step();
  endtask

  task automatic start_line();
    ls_req = 1'b1; step(); ls_req = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    under_m = 1'b0; over_m = 1'b0; last_head = '0;
    gen++;
    grants_cur = 0; inflight_cur = 0; delivered_cur = 0; words_cur = 0;
    active = 1'b0; idle_cnt = 3;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    for (int i = 0; i <= DEPTH; i++) pp_cnt[i] = 0;
    rst = 1'b1;
    line_start = 0; vpix = 0; int_start = 0; video_next = 0; video_strobe = 0;
    dram_rddata = '0; fifo_rd = 0;
    ls_req = 0; vpix_req = 1; is_req = 0; pop_force = 0;
    set_mode(0);
    grant_gap = 0; grant_pct = 100; lat_min = 2; lat_max = 2;
    pop_pct = 100; bogus_pct = 0; strobe_pct = 100;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");
    check("reset_state", 32'(dbg_state), 32'(0));

    // zx line: grant every 4 cycles, return 2 cycles later, continuous pops
    set_mode(0); grant_gap = 4;
    start_line();
    check("req_rise", 32'(video_req), 32'(1));
    run_line(2000);
    check("zx_grants", 32'(grants_cur), 32'(32));
    check("zx_delivered", 32'(delivered_cur), 32'(32));

    // ag line with stalled serializer: credit limits grants
    set_mode(3); grant_gap = 0; pop_pct = 0; bogus_pct = 20;
    start_line();
    repeat (20) step();
    check("stall_grants", 32'(grants_cur), 32'(DEPTH));
    check("stall_req_low", 32'(video_req), 32'(0));
    pop_force = 1'b1; step(); pop_force = 1'b0;
    repeat (10) step();
    check("stall_one_more", 32'(grants_cur), 32'(DEPTH + 1));
    pop_pct = 100;
    run_line(2000);
    check("ag_grants", 32'(grants_cur), 32'(80));
    check("ag_delivered", 32'(delivered_cur), 32'(80));

    // restart mid-line with two words in flight
    set_mode(0); bogus_pct = 0; lat_min = 3; lat_max = 3;
    start_line();
    n = 0;
    while (!(inflight_cur == 2 && grants_cur < words_cur) && n < 100) begin step(); n++; end
    check("ovr_setup", 32'(inflight_cur), 32'(2));
    start_line();
    check("ovr_flag", 32'(overrun), 32'(1));
    check("ovr_flush", 32'(fifo_empty), 32'(1));
    run_line(2000);
    check("ovr_grants", 32'(grants_cur), 32'(32));
    check("ovr_delivered", 32'(delivered_cur), 32'(32));

    // pop while empty, then frame start clears both flags
    pop_force = 1'b1; step(); pop_force = 1'b0;
    check("udr_flag", 32'(underrun), 32'(1));
    check("udr_rdata_hold", 32'(fifo_rdata), 32'(last_head));
    is_req = 1'b1; step(); is_req = 1'b0;
    check("int_clr_under", 32'(underrun), 32'(0));
    check("int_clr_over", 32'(overrun), 32'(0));

    // lines that must not start
    set_mode(5); start_line(); repeat (3) step();
    check("nomode_idle", 32'(busy), 32'(0));
    set_mode(0); vpix_req = 1'b0; start_line(); vpix_req = 1'b1; repeat (3) step();
    check("novpix_idle", 32'(busy), 32'(0));

    // randomized lines with occasional restarts and frame starts
    for (int ln = 0; ln < 30 && (ln < 8 || pp_cnt[DEPTH-1] == 0 || pp_cnt[1] == 0); ln++) begin
      set_mode(int'($urandom_range(4, 0)));
      grant_gap  = int'($urandom_range(2, 0));
      grant_pct  = int'($urandom_range(100, 40));
      lat_min    = 1;
      lat_max    = int'($urandom_range(6, 1));
      pop_pct    = int'($urandom_range(90, 30));
      bogus_pct  = 10;
      strobe_pct = int'($urandom_range(100, 50));
      start_line();
      if (ln % 4 == 1 || ln % 4 == 2) begin
        repeat (int'($urandom_range(20, 3))) step();
        if (active && grants_cur < words_cur) begin
          if (ln % 4 == 1) ls_req = 1'b1; else is_req = 1'b1;
          step();
          ls_req = 1'b0; is_req = 1'b0;
        end
      end
      run_line(4000);
    end
    check("cov_pp_full_minus1", 32'(pp_cnt[DEPTH-1] > 0), 32'(1));
    check("cov_pp_one", 32'(pp_cnt[1] > 0), 32'(1));

    // asynchronous reset in DRAIN, then stray returns
    set_mode(0); grant_gap = 0; grant_pct = 100; lat_min = 4; lat_max = 4;
    pop_pct = 100; bogus_pct = 0; strobe_pct = 100;
    is_req = 1'b1; step(); is_req = 1'b0;
    repeat (6) step();
    start_line();
    n = 0;
    while (dbg_state != 2'd2 && n < 200) begin step(); n++; end
    check("drain_reached", 32'(dbg_state), 32'(2));
    #5 rst = 1'b1;
    #1;
    check_reset_outputs("rstmid");
    check("rstmid_state", 32'(dbg_state), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    pend_due.delete(); pend_tag.delete();
    for (int i = 0; i < 3; i++) begin
      pend_due.push_back(cyc);
      pend_tag.push_back(gen - 1);
    end
    repeat (5) step();
    check("stray_empty", 32'(fifo_empty), 32'(1));
    check("stray_busy", 32'(busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
